// File: rtl/gs_pkg.sv
`default_nettype none
// ============================================================================
// Module : gs_pkg
// Brief  : Shared types and constants for the gs instruction-memory responder.
// Rev    : 1.0  initial release
// ============================================================================
package gs_pkg;

  localparam int IMEM_LAT_MAX = 4;

  typedef enum logic [0:0] {
    IMEM_IDLE = 1'b0,
    IMEM_BUSY = 1'b1
  } imem_fsm_e;

endpackage
`default_nettype wire

// File: rtl/gs_imem_resp_pipe.sv
`default_nettype none
// ============================================================================
// Module : gs_imem_resp_pipe
// Brief  : DEPTH-stage valid/index/error shift pipeline with synchronous kill.
// Rev    : 1.0  initial release
// ============================================================================
module gs_imem_resp_pipe #(
  parameter int DEPTH = 1,
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kill_i,
  input  logic             in_valid_i,
  input  logic [IDX_W-1:0] in_idx_i,
  input  logic             in_err_i,
  output logic             pre_valid_o,
  output logic [IDX_W-1:0] pre_idx_o,
  output logic             pre_err_o,
  output logic             out_valid_o,
  output logic             out_err_o
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] err_q, err_d;
  logic [IDX_W-1:0] idx_q [DEPTH];
  logic [IDX_W-1:0] idx_d [DEPTH];

  always_comb begin
    valid_d[0] = in_valid_i;
    err_d[0]   = in_err_i;
    idx_d[0]   = in_idx_i;
    for (int s = 1; s < DEPTH; s++) begin
      valid_d[s] = valid_q[s-1];
      err_d[s]   = err_q[s-1];
      idx_d[s]   = idx_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      err_q   <= '0;
      idx_q   <= '{default: '0};
    end else begin
      valid_q <= kill_i ? '0 : valid_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
    end
  end

  // "pre" is what enters the last stage on the coming edge; the data read is
  // taken there so the output data register lines up with out_valid_o.
  assign pre_valid_o = valid_d[DEPTH-1];
  assign pre_idx_o   = idx_d[DEPTH-1];
  assign pre_err_o   = err_d[DEPTH-1];
  assign out_valid_o = valid_q[DEPTH-1];
  assign out_err_o   = err_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/gs_imem_responder.sv
`default_nettype none
// ============================================================================
// Module : gs_imem_responder
// Brief  : Instruction-memory responder with fixed-latency in-order responses,
//          outstanding limit, flush and preload port. Optional GS_IMEM_STATS_EN
//          adds saturating grant/error counters.
// Rev    : 1.0  initial release
// ============================================================================
module gs_imem_responder
  import gs_pkg::*;
#(
  parameter int                   ADDR_SIZE       = 32,
  parameter int                   WORD_SIZE       = 32,
  parameter int                   DEPTH_WORDS     = 1024,
  parameter logic [ADDR_SIZE-1:0] BASE_ADDR       = '0,
  parameter int                   LATENCY         = 1,
  parameter int                   MAX_OUTSTANDING = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_req_i,
  input  logic [ADDR_SIZE-1:0] instr_addr_i,
  output logic                 instr_gnt_o,
  output logic                 instr_rvalid_o,
  output logic [WORD_SIZE-1:0] instr_rdata_o,
  output logic                 instr_err_o,
  input  logic                 flush_i,
  input  logic                 load_we_i,
  input  logic [ADDR_SIZE-1:0] load_addr_i,
  input  logic [WORD_SIZE-1:0] load_data_i
`ifdef GS_IMEM_STATS_EN
  ,
  output logic [31:0]          stat_req_o,
  output logic [15:0]          stat_err_o
`endif
);

  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int PIPE_D = (LATENCY < 1) ? 1 :
                          (LATENCY > IMEM_LAT_MAX) ? IMEM_LAT_MAX : LATENCY;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [WORD_SIZE-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_SIZE-1:0] rdata_q;
  logic [CNT_W-1:0]     count_q, count_d;
  imem_fsm_e            state_q, state_d;

  logic [ADDR_SIZE-1:0] req_off, load_off;
  logic                 req_bad, load_bad;
  logic [IDX_W-1:0]     req_idx, load_idx;
  logic                 gnt, retire;
  logic                 pre_valid, pre_err, out_valid, out_err;
  logic [IDX_W-1:0]     pre_idx;

  // Offset is unsigned, so addresses below BASE_ADDR wrap high and fail.
  assign req_off  = instr_addr_i - BASE_ADDR;
  assign req_bad  = (instr_addr_i[1:0] != 2'b00) ||
                    ((req_off >> 2) >= ADDR_SIZE'(DEPTH_WORDS));
  assign req_idx  = req_off[IDX_W+1:2];
  assign load_off = load_addr_i - BASE_ADDR;
  assign load_bad = (load_addr_i[1:0] != 2'b00) ||
                    ((load_off >> 2) >= ADDR_SIZE'(DEPTH_WORDS));
  assign load_idx = load_off[IDX_W+1:2];

  assign retire = out_valid;
  assign gnt    = instr_req_i & ~flush_i & ~load_we_i &
                  ((count_q < MAX_CNT) | retire);

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      case ({gnt, retire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IMEM_IDLE;
    end else begin
      case (state_q)
        IMEM_IDLE: if (gnt) state_d = IMEM_BUSY;
        IMEM_BUSY: if ((count_d == '0) && !gnt) state_d = IMEM_IDLE;
        default:   state_d = IMEM_IDLE;
      endcase
    end
  end

  gs_imem_resp_pipe #(
    .DEPTH (PIPE_D),
    .IDX_W (IDX_W)
  ) u_pipe (
    .clk         (clk),
    .rst         (rst),
    .kill_i      (flush_i),
    .in_valid_i  (gnt),
    .in_idx_i    (req_idx),
    .in_err_i    (req_bad),
    .pre_valid_o (pre_valid),
    .pre_idx_o   (pre_idx),
    .pre_err_o   (pre_err),
    .out_valid_o (out_valid),
    .out_err_o   (out_err)
  );

  always_ff @(posedge clk) begin
    if (load_we_i && !load_bad) begin
      mem_q[load_idx] <= load_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      state_q <= IMEM_IDLE;
      rdata_q <= '0;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      if (pre_valid && !flush_i) begin
        rdata_q <= pre_err ? '0 : mem_q[pre_idx];
      end
    end
  end

  assign instr_gnt_o    = gnt;
  assign instr_rvalid_o = out_valid;
  assign instr_err_o    = out_valid & out_err;
  assign instr_rdata_o  = rdata_q;

`ifdef GS_IMEM_STATS_EN
  logic [31:0] stat_req_q;
  logic [15:0] stat_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_req_q <= '0;
      stat_err_q <= '0;
    end else begin
      if (gnt && (stat_req_q != '1)) stat_req_q <= stat_req_q + 32'd1;
      if (out_valid && out_err && (stat_err_q != '1)) stat_err_q <= stat_err_q + 16'd1;
    end
  end

  assign stat_req_o = stat_req_q;
  assign stat_err_o = stat_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gs_imem_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_gs_imem_responder
// Brief  : Directed scoreboard bench for gs_imem_responder (LATENCY=3, MAX=2).
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_gs_imem_responder;

  localparam int LAT   = 3;
  localparam int MAXO  = 2;
  localparam int DEPTH = 256;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, flush = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, laddr = '0, ldata = '0;
  logic        gnt, rvalid, err;
  logic [31:0] rdata;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [31:0] exp_last = '0;

  gs_imem_responder #(
    .ADDR_SIZE       (32),
    .WORD_SIZE       (32),
    .DEPTH_WORDS     (DEPTH),
    .BASE_ADDR       (32'h0),
    .LATENCY         (LAT),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk            (clk),
    .rst            (rst_n),
    .instr_req_i    (req),
    .instr_addr_i   (addr),
    .instr_gnt_o    (gnt),
    .instr_rvalid_o (rvalid),
    .instr_rdata_o  (rdata),
    .instr_err_o    (err),
    .flush_i        (flush),
    .load_we_i      (we),
    .load_addr_i    (laddr),
    .load_data_i    (ldata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every response must match the head of the queue at its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      checks++;
      if (rvalid) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rvalid cyc=%0d got data=%h err=%b", cyc, rdata, err);
        end else begin
          e = sb.pop_front();
          if (rdata !== e.data || err !== e.err || cyc != e.due) begin
            errors++;
            $display("FAIL resp cyc=%0d got data=%h err=%b, exp data=%h err=%b due=%0d",
                     cyc, rdata, err, e.data, e.err, e.due);
          end
          exp_last = e.data;
        end
      end else if (rdata !== exp_last) begin
        errors++;
        $display("FAIL rdata_hold cyc=%0d got=%h exp=%h", cyc, rdata, exp_last);
      end
    end
  end

  task automatic drive(input logic r, input logic [31:0] a, input logic f,
                       input logic w, input logic [31:0] la, input logic [31:0] ld,
                       input logic eg, input logic [31:0] ed, input logic ee);
    exp_t e;
    @(posedge clk); #1;
    req = r; addr = a; flush = f; we = w; laddr = la; ldata = ld;
    @(negedge clk);
    if (f) sb.delete();
    checks++;
    if (gnt !== eg) begin
      errors++;
      $display("FAIL gnt cyc=%0d addr=%h got=%b exp=%b", cyc, a, gnt, eg);
    end
    if (eg) begin
      e.data = ed; e.err = ee; e.due = cyc + LAT;
      sb.push_back(e);
    end
  endtask

  task automatic rq(input logic [31:0] a, input logic eg, input logic [31:0] ed, input logic ee);
    drive(1'b1, a, 1'b0, 1'b0, '0, '0, eg, ed, ee);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic load(input logic [31:0] la, input logic [31:0] ld);
    drive(1'b0, '0, 1'b0, 1'b1, la, ld, 1'b0, '0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rvalid", {31'd0, rvalid}, 32'd0);
    chk("reset_err",    {31'd0, err},    32'd0);
    chk("reset_rdata",  rdata,           32'd0);
    chk("reset_gnt",    {31'd0, gnt},    32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    load(32'h100, 32'hDEADBEEF);
    load(32'h000, 32'h11111111);
    load(32'h004, 32'h22222222);
    load(32'h008, 32'h33333333);
    load(32'h3FC, 32'hCAFEF00D);
    load(32'h020, 32'h00000020);
    load(32'h400, 32'h0BAD0BAD);   // out of range: must not alias word 0
    load(32'h005, 32'h0BAD0005);   // misaligned: must not touch word 1

    // single fetch
    rq(32'h100, 1'b1, 32'hDEADBEEF, 1'b0);
    idle(4);

    // outstanding limit: third request stalls until first retires
    rq(32'h000, 1'b1, 32'h11111111, 1'b0);
    rq(32'h004, 1'b1, 32'h22222222, 1'b0);
    rq(32'h008, 1'b0, '0, 1'b0);
    rq(32'h008, 1'b1, 32'h33333333, 1'b0);
    idle(5);

    // error responses and last legal word
    rq(32'h102,      1'b1, 32'h0, 1'b1);
    rq(32'h400,      1'b1, 32'h0, 1'b1);
    rq(32'h3FC,      1'b0, '0,    1'b0);
    rq(32'h3FC,      1'b1, 32'hCAFEF00D, 1'b0);
    rq(32'hFFFFFFFC, 1'b1, 32'h0, 1'b1);
    idle(5);

    // flush kills in-flight request and clears the outstanding count
    rq(32'h000, 1'b1, 32'h11111111, 1'b0);
    drive(1'b1, 32'h004, 1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    rq(32'h008, 1'b1, 32'h33333333, 1'b0);
    rq(32'h000, 1'b1, 32'h11111111, 1'b0);
    rq(32'h004, 1'b0, '0, 1'b0);
    rq(32'h004, 1'b1, 32'h22222222, 1'b0);
    idle(5);

    // preload wins over a same-cycle request; next read sees new data
    drive(1'b1, 32'h020, 1'b0, 1'b1, 32'h020, 32'hA5A50020, 1'b0, '0, 1'b0);
    rq(32'h020, 1'b1, 32'hA5A50020, 1'b0);
    idle(5);

    // asynchronous reset while a response is showing and another is in flight
    rq(32'h100, 1'b1, 32'hDEADBEEF, 1'b0);
    rq(32'h004, 1'b1, 32'h22222222, 1'b0);
    idle(2);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_rvalid", {31'd0, rvalid}, 32'd0);
    chk("midreset_err",    {31'd0, err},    32'd0);
    chk("midreset_rdata",  rdata,           32'd0);
    sb.delete();
    exp_last = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(6);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending_responses got=%0d exp=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gs_imem_responder.md
Name: gs_imem_responder

Overview:
Instruction-memory responder: the memory-side end of the fetch interface driven by the IF stage. It accepts word-fetch requests, grants them subject to an outstanding-request limit, and returns data, valid and error a fixed LATENCY cycles after grant. Internal word array with a preload write port (testbench/boot loader). Sits between GS_IF_STAGE and the instruction SRAM/ROM.

Parameters:
ADDR_SIZE, 32, request address width
WORD_SIZE, 32, data word width
DEPTH_WORDS, 1024, array depth in words (power of 2)
BASE_ADDR, 0, byte address of word 0
LATENCY, 1, grant-to-rvalid cycles, legal 1..4
MAX_OUTSTANDING, 2, max granted-but-unanswered requests, legal 1..LATENCY+1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
instr_req_i  in  1  fetch request
instr_addr_i  in  ADDR_SIZE  byte address of request
instr_gnt_o  out  1  request accepted this cycle (combinational)
instr_rvalid_o  out  1  response valid
instr_rdata_o  out  WORD_SIZE  response data
instr_err_o  out  1  response is an error (misaligned/out of range)
flush_i  in  1  discard all in-flight responses
load_we_i  in  1  preload write enable
load_addr_i  in  ADDR_SIZE  preload byte address
load_data_i  in  WORD_SIZE  preload data

Behaviour:
- Reset (rst=0, async): rvalid_o=0, rdata_o=0, err_o=0, outstanding count=0, pipeline valids cleared, FSM=IDLE. Array contents not reset.
- gnt_o = req_i & !flush_i & !load_we_i & (count < MAX_OUTSTANDING | a response retires this cycle).
- Granted request enters a LATENCY-deep stage pipeline carrying valid, word index and error flag; array read is captured so rdata/rvalid/err are registered outputs exactly LATENCY cycles after the grant edge. Back-to-back grants give back-to-back responses, in order.
- Error: addr[1:0]!=0 or (addr-BASE_ADDR)>>2 >= DEPTH_WORDS (unsigned, wrap-around counts as out of range) -> rvalid=1, err=1, rdata=0, no array access.
- count: +1 on grant, -1 on rvalid; both in one cycle -> unchanged. Never exceeds MAX_OUTSTANDING.
- flush_i: all pipeline valids and count cleared on next edge; no rvalid for any request granted before or in the flush cycle. rvalid_o is 0 in the cycle after flush.
- Preload: write on clk edge when load_we_i=1 and the address is legal; illegal preload is ignored. Write has priority (gnt=0). A read granted after the write edge returns new data.
- FSM: IDLE (count=0, no grant) -> BUSY on grant; BUSY -> IDLE when count reaches 0 with no new grant; any state -> IDLE on flush. FSM state is debug-visible only; it does not gate outputs.
- rdata_o holds its last value while rvalid_o=0.

Optional Feature:
GS_IMEM_STATS_EN: adds outputs stat_req_o[31:0] (granted requests) and stat_err_o[15:0] (error responses). Both are saturating, cleared on reset, and unaffected by flush. Without the macro these ports and counters do not exist.

Decomposition:
- gs_pkg gains imem_fsm_e {IMEM_IDLE, IMEM_BUSY} and constant IMEM_LAT_MAX=4.
- Sub-module gs_imem_resp_pipe: parameterised valid/index/err shift pipeline with synchronous kill (flush).

Test Plan:
- Preload 0x100=0xDEADBEEF, LATENCY=1, req addr 0x100 at cycle 0 -> gnt=1 at c0; rvalid=1, rdata=0xDEADBEEF, err=0 at c1.
- LATENCY=3, MAX_OUTSTANDING=2, req held high for addrs 0x0,0x4,0x8 -> gnt at c0,c1; stall; c3 rvalid for 0x0 frees slot and gnt for 0x8 at c3; responses in order at c3, c4, c6.
- req addr 0x102 -> rvalid=1, err=1, rdata=0. req addr BASE+DEPTH_WORDS*4 -> err=1.
- LATENCY=2, grant 0x0 at c0, flush_i=1 at c1 -> no rvalid at c2/c3; count=0; new req at c2 granted.
- load_we_i=1 to 0x20 and req 0x20 in the same cycle -> gnt=0; next cycle req is granted and returns the newly written data.
- Reset asserted mid-burst with 2 outstanding -> rvalid/err/rdata=0 immediately; after release no stale response appears.
